// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver frame controller: frame geometry,
// the fixed 64-bit bit-interleave table and the two FSM state encodings.
package interleaver_pkg;

  localparam int FRAME_BITS  = 64;
  localparam int FRAME_BYTES = FRAME_BITS / 8;

  // Output index k (MSB-first, index 0 = bit 63) takes input index P[k].
  localparam logic [5:0] P [FRAME_BITS] = '{
    6'd53, 6'd40, 6'd27, 6'd14, 6'd1,  6'd54, 6'd50, 6'd33,
    6'd15, 6'd6,  6'd56, 6'd43, 6'd36, 6'd17, 6'd10, 6'd60,
    6'd44, 6'd31, 6'd21, 6'd8,  6'd55, 6'd42, 6'd35, 6'd16,
    6'd9,  6'd58, 6'd46, 6'd37, 6'd19, 6'd2,  6'd51, 6'd38,
    6'd25, 6'd12, 6'd63, 6'd41, 6'd32, 6'd24, 6'd7,  6'd61,
    6'd48, 6'd29, 6'd22, 6'd3,  6'd57, 6'd47, 6'd34, 6'd18,
    6'd5,  6'd62, 6'd49, 6'd30, 6'd23, 6'd4,  6'd59, 6'd45,
    6'd28, 6'd20, 6'd11, 6'd52, 6'd39, 6'd26, 6'd13, 6'd0
  };

  // Collector side: filling the assembly register, or holding a full frame.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } coll_state_t;

  // Output side: nothing to send, or streaming the output register.
  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } out_state_t;

endpackage

// File: rtl/interleave_perm_64.sv
// Purely combinational 64-bit bit permutation driven by the shared table P.
// Bit indices are MSB-first, so index i lives at vector bit 63-i.
module interleave_perm_64
  import interleaver_pkg::*;
(
  input  logic [FRAME_BITS-1:0] din,
  output logic [FRAME_BITS-1:0] dout
);

  // One wire per output bit, routed from the table-selected input bit.
  for (genvar k = 0; k < FRAME_BITS; k++) begin : g_bit
    assign dout[FRAME_BITS-1-k] = din[FRAME_BITS-1-int'(P[k])];
  end

endmodule

// File: rtl/interleaver_frame_ctrl.sv
// Frame controller: collects SPI bytes into 64-bit frames, bit-interleaves
// them and streams the result out byte by byte over valid/ready.
// Collection and transmission are double-buffered (assembly + output reg).
//
// Handshake: o_TX_Valid is raised with o_TX_Byte and both are held stable
// until a cycle where o_TX_Valid and i_TX_Ready are both high; that cycle is
// the transfer. o_TX_Valid never depends combinationally on i_TX_Ready.
//
// FSM state is visible to checkers as c_state (collector) and o_state
// (output side), alongside c_count and byte_idx.
module interleaver_frame_ctrl
  import interleaver_pkg::*;
#(
  parameter int DATABYTES = 8  // must be 8 to match the 64-entry table
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_RX_Byte,
  input  logic        i_RX_Ready,
  input  logic        i_CS_n,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_Valid,
  input  logic        i_TX_Ready,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Drop,
  output logic        o_Abort,
  output logic [15:0] o_Frame_Count
);

  localparam logic [3:0] LAST_COUNT = 4'(DATABYTES - 1);

  logic                  r_prev;
  coll_state_t           c_state;
  logic [3:0]            c_count;
  logic [FRAME_BITS-1:0] asm_reg;
  out_state_t            o_state;
  logic [2:0]            byte_idx;
  logic [FRAME_BITS-1:0] out_reg;
  logic [FRAME_BITS-1:0] perm_word;

  logic                  strobe;
  logic                  load;
  logic                  xfer;
  logic                  last_xfer;
  logic                  abort_now;
  logic                  drop_now;
  logic [3:0]            count_nx;
  logic [2:0]            idx_nx;
  logic                  busy_nx;

  interleave_perm_64 u_perm (
    .din  (asm_reg),
    .dout (perm_word)
  );

  // Event decode shared by both FSMs, plus next count for the busy flag.
  always_comb begin
    strobe    = i_RX_Ready & ~r_prev;
    load      = (c_state == FULL) && (o_state == EMPTY);
    xfer      = (o_state == SEND) && o_TX_Valid && i_TX_Ready;
    last_xfer = xfer && (byte_idx == 3'd7);
    abort_now = (c_state == COLLECT) && i_CS_n && !strobe && (c_count != 4'd0);
    drop_now  = (c_state == FULL) && strobe && !load;
    idx_nx    = byte_idx + 3'd1;
    count_nx  = c_count;
    case (c_state)
      COLLECT: begin
        if (strobe)         count_nx = c_count + 4'd1;
        else if (abort_now) count_nx = 4'd0;
      end
      FULL: begin
        // A strobe on the hand-off cycle becomes byte 1 of the next frame.
        if (load) count_nx = strobe ? 4'd1 : 4'd0;
      end
      default: count_nx = c_count;
    endcase
    busy_nx = (count_nx != 4'd0) || load || ((o_state == SEND) && !last_xfer);
  end

  // Collector FSM: strobe edge detect, byte assembly, overflow and abort pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      c_state <= COLLECT;
      c_count <= 4'd0;
      asm_reg <= '0;
      o_Drop  <= 1'b0;
      o_Abort <= 1'b0;
    end else begin
      r_prev  <= i_RX_Ready;
      c_count <= count_nx;
      o_Drop  <= drop_now;
      o_Abort <= abort_now;
      case (c_state)
        COLLECT: begin
          if (strobe) begin
            asm_reg <= {asm_reg[FRAME_BITS-9:0], i_RX_Byte};
            if (c_count == LAST_COUNT) c_state <= FULL;
          end
        end
        FULL: begin
          if (load) begin
            c_state <= COLLECT;
            if (strobe) asm_reg <= {asm_reg[FRAME_BITS-9:0], i_RX_Byte};
          end
        end
        default: c_state <= COLLECT;
      endcase
    end
  end

  // Output FSM: load the permuted frame, stream bytes MSB first, count frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_state       <= EMPTY;
      byte_idx      <= 3'd0;
      out_reg       <= '0;
      o_TX_Byte     <= 8'd0;
      o_TX_Valid    <= 1'b0;
      o_Busy        <= 1'b0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Count <= 16'd0;
    end else begin
      o_Busy       <= busy_nx;
      o_Frame_Done <= 1'b0;
      case (o_state)
        EMPTY: begin
          if (load) begin
            o_state    <= SEND;
            out_reg    <= perm_word;
            byte_idx   <= 3'd0;
            o_TX_Byte  <= perm_word[FRAME_BITS-1 -: 8];
            o_TX_Valid <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_xfer) begin
              o_state       <= EMPTY;
              o_TX_Valid    <= 1'b0;
              o_Frame_Done  <= 1'b1;
              o_Frame_Count <= o_Frame_Count + 16'd1;
            end else begin
              byte_idx  <= idx_nx;
              o_TX_Byte <= out_reg[(FRAME_BITS-1) - 8*int'(idx_nx) -: 8];
            end
          end
        end
        default: o_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/interleaver_frame_ctrl.md
# interleaver_frame_ctrl

Frame controller that sits between the SPI byte receiver and the downstream byte consumer. It assembles received bytes into 64-bit frames and applies the fixed 64-bit bit-interleave permutation. It then streams the interleaved frame out byte by byte over a valid/ready handshake. Collection and transmission are double-buffered, so one frame can be received while the previous one drains; overflow and mid-frame chip-select aborts are detected and flagged.

## Interface
- DATABYTES, 8, bytes per frame; only legal value is 8, matching the 64-entry permutation table.
- clk  in  1  system clock; every output is registered on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_RX_Byte  in  8  byte from the SPI receiver.
- i_RX_Ready  in  1  level "byte valid" from the SPI receiver; each rising edge delivers one byte.
- i_CS_n  in  1  SPI chip select, synchronous to clk.
- o_TX_Byte  out  8  interleaved output byte.
- o_TX_Valid  out  1  o_TX_Byte is valid.
- i_TX_Ready  in  1  consumer accepts the byte; a transfer occurs when o_TX_Valid and i_TX_Ready are both high.
- o_Busy  out  1  high when the collector count is nonzero or the output side is not EMPTY.
- o_Frame_Done  out  1  one-cycle pulse when the last byte of a frame is transferred.
- o_Drop  out  1  one-cycle pulse when a received byte is discarded due to overflow.
- o_Abort  out  1  one-cycle pulse when a partial frame is discarded because i_CS_n went high.
- o_Frame_Count  out  16  completed frames; wraps from 0xFFFF to 0.

## Operation
- **Byte strobe.** i_RX_Ready is registered into r_prev. The strobe is i_RX_Ready & ~r_prev, and the byte is taken in the same cycle.
- **Collector FSM, state COLLECT.**
  - On a strobe, shift the byte into a 64-bit assembly register: the first byte lands in bits [63:56] after 8 shifts.
  - Increment the 4-bit count. When the 8th byte arrives, go to FULL.
- **Collector FSM, state FULL.**
  - Wait until the output side is EMPTY.
  - On that cycle, load the permuted assembly word into the output register, clear the count and return to COLLECT.
  - A strobe in this transfer cycle is accepted as byte 1 of the next frame.
  - A strobe in any other FULL cycle is discarded and pulses o_Drop.
- **Abort.** If i_CS_n is high in COLLECT with a count of 1..7 and no strobe, clear the count and pulse o_Abort. i_CS_n has no effect in FULL or on the output side.
- **Permutation.** Bits are indexed MSB-first (index 0 = bit 63). Output index k takes input index P[k].
  - P = 53,40,27,14,1,54,50,33,15,6,56,43,36,17,10,60,44,31,21,8,55,42,35,16,9,58,46,37,19,2,51,38,25,12,63,41,32,24,7,61,48,29,22,3,57,47,34,18,5,62,49,30,23,4,59,45,28,20,11,52,39,26,13,0.
- **Output FSM.**
  - EMPTY → SEND on load from the collector, with a 3-bit byte index set to 0.
  - SEND: o_TX_Byte = output register byte [index], MSB byte first, and o_TX_Valid = 1.
  - On a transfer, increment the index.
  - On the transfer at index 7: go to EMPTY, pulse o_Frame_Done, increment o_Frame_Count.
  - o_TX_Byte and o_TX_Valid must not change while o_TX_Valid=1 and i_TX_Ready=0.

## Timing
- **Reset values.** Assertion of rst_n clears, asynchronously and at any point mid-frame:
  - o_TX_Byte=0, o_TX_Valid=0, o_Busy=0, o_Frame_Done=0, o_Drop=0, o_Abort=0, o_Frame_Count=0;
  - collector to COLLECT with count 0, output FSM to EMPTY, r_prev=0, assembly and output registers to 0.
  - A partial frame is lost silently; no o_Abort pulse.
- **Latency.** The 8th strobe at cycle N puts the collector in FULL at N+1. If the output side is EMPTY, the load happens at N+1 and o_TX_Valid is high at N+2.
- **Transfer rate.** One byte per cycle while i_TX_Ready=1.
- **Inter-frame gap.** There is at least one cycle with o_TX_Valid=0 between frames: EMPTY is entered, then the load happens.
- **Strobe spacing.** Back-to-back strobes need i_RX_Ready to go low for at least one cycle between them.

## Structure
- **Shared package interleaver_pkg holds:**
  - the permutation table constant P (64 × 6-bit);
  - FRAME_BITS = 64;
  - the collector state encoding (COLLECT, FULL);
  - the output state encoding (EMPTY, SEND).
- **Sub-module interleave_perm_64:** a purely combinational 64-bit permutation driven by P. It is instantiated once, on the assembly register output.

## Test plan
- **Single-bit mapping, input index 0.** Send frame 0x80,00,00,00,00,00,00,00 with i_TX_Ready=1 → output bytes 00,00,00,00,00,00,00,01; one o_Frame_Done pulse; o_Frame_Count=1.
- **Single-bit mapping, input index 53.** Send frame 00,00,00,00,00,00,04,00 → output 80,00,00,00,00,00,00,00; first o_TX_Valid appears 2 cycles after the 8th strobe.
- **Backpressure and overflow.**
  - Hold i_TX_Ready=0 and send 3 full frames → frame 1 stalls on byte 0 with stable data; frame 2 sits in FULL; every byte of frame 3 pulses o_Drop (8 pulses).
  - Release i_TX_Ready → frames 1 and 2 are output intact; o_Frame_Count=2.
- **Chip-select abort.** Send 5 bytes, raise i_CS_n → one o_Abort pulse. Then send a full frame 0xFF×8 → output 0xFF×8.
- **Reset mid-operation.** Assert rst_n during SEND at index 3 → all outputs go to their reset values immediately. After release, a new frame is processed normally and o_Frame_Count=1.
- **Counter wrap.** Preload or run 65536 frames → o_Frame_Count reads 0 after the wrap, and o_Frame_Done still pulses.
